// File: rtl/pulse_stretcher_pkg.sv
// Shared helpers for the pulse stretcher: counter sizing for a given hold length.
package pulse_stretcher_pkg;

    // Width of a down-counter that must hold the value hold_cycles.
    // Clamped to 1 so that an illegal hold length still yields a legal
    // vector while the top-level check reports the error.
    function automatic int cnt_width(input int hold_cycles);
        int w;
        w = $clog2(hold_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_stretcher_ch.sv
// One stretcher channel: a reloadable down-counter plus a registered done flag.
module pulse_stretcher_ch
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int RETRIGGER   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic level_out,
    output logic done
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             idle;
    logic             load;

    assign idle = (cnt == '0);
    // While active, a trigger only matters when retriggering is enabled.
    assign load = trig && (idle || (RETRIGGER != 0));

    // Reload on an accepted trigger, otherwise count down to zero and flag the final step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= RELOAD;
            done <= 1'b0;
        end else if (!idle) begin
            cnt  <= cnt - LAST;
            done <= (cnt == LAST);
        end else begin
            done <= 1'b0;
        end
    end

    assign level_out = !idle;

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse-to-level stretcher: WIDTH independent channels plus an activity summary.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int RETRIGGER   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] trig,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] done,
    output logic             any_active
);

    // A zero-length hold has no meaningful behaviour; refuse to build it.
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("pulse_stretcher: HOLD_CYCLES must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pulse_stretcher_ch #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .RETRIGGER   (RETRIGGER)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .trig      (trig[i]),
            .level_out (level_out[i]),
            .done      (done[i])
        );
    end

    // Straight reduction of the registered levels, so no extra latency.
    assign any_active = |level_out;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: five parameter sets driven with shared stimulus and
// checked against a time-stamp model (hold start edge vs. current edge).
module tb_pulse_stretcher;

    localparam int ND = 5;
    localparam int NC = 3;
    localparam int HS [ND] = '{5, 5, 1, 3, 3};
    localparam int RS [ND] = '{1, 0, 1, 0, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] trig;
    logic [NC-1:0] lvl [ND];
    logic [NC-1:0] dn  [ND];
    logic          act [ND];

    always #5 clk = ~clk;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        pulse_stretcher #(
            .WIDTH       (NC),
            .HOLD_CYCLES (HS[k]),
            .RETRIGGER   (RS[k])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .trig       (trig),
            .level_out  (lvl[k]),
            .done       (dn[k]),
            .any_active (act[k])
        );
    end

    int total = 0;
    int bad   = 0;

    // Model: for each channel remember the edge index at which the current
    // hold started; level and done follow from the elapsed edge count.
    int edge_n = 0;
    bit has_s [ND][NC];
    int s_at  [ND][NC];

    function automatic logic mdl_level(input int k, input int c, input int e);
        return has_s[k][c] && ((e - s_at[k][c]) < HS[k]);
    endfunction

    function automatic logic mdl_done(input int k, input int c, input int e);
        return has_s[k][c] && ((e - s_at[k][c]) == HS[k]);
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] actual, input logic [31:0] expect_v);
        total++;
        if (actual !== expect_v) begin
            bad++;
            $display("FAIL %s dut%0d edge=%0d got=%0h want=%0h", name, k, edge_n, actual, expect_v);
        end
    endtask

    task automatic step(input logic r, input logic [NC-1:0] t);
        logic [NC-1:0] el, ed;
        rst_n = r;
        trig  = t;
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < ND; k++) begin
            for (int c = 0; c < NC; c++) begin
                if (!r) begin
                    has_s[k][c] = 1'b0;
                end else if (t[c]) begin
                    if (!mdl_level(k, c, edge_n - 1) || (RS[k] != 0)) begin
                        has_s[k][c] = 1'b1;
                        s_at[k][c]  = edge_n;
                    end
                end
            end
        end
        #1;
        for (int k = 0; k < ND; k++) begin
            el = '0;
            ed = '0;
            for (int c = 0; c < NC; c++) begin
                el[c] = mdl_level(k, c, edge_n);
                ed[c] = mdl_done(k, c, edge_n);
            end
            check("level", k, 32'(lvl[k]), 32'(el));
            check("done", k, 32'(dn[k]), 32'(ed));
            check("any", k, 32'(act[k]), 32'(|el));
        end
    endtask

    typedef struct {
        logic [NC-1:0] t;
        logic [NC-1:0] l0, d0, l1, d1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Trigger at relative edge 0 and 3: dut0 (retrigger) extends, dut1 ignores.
        tbl[0]  = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b000};
        tbl[1]  = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
        tbl[2]  = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
        tbl[3]  = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b000};
        tbl[4]  = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
        tbl[5]  = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b001};
        tbl[6]  = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[7]  = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[8]  = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
        tbl[9]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

        for (int k = 0; k < ND; k++)
            for (int c = 0; c < NC; c++) begin
                has_s[k][c] = 1'b0;
                s_at[k][c]  = 0;
            end

        rst_n = 1'b0;
        trig  = '0;
        step(0, '0);
        step(0, '0);
        for (int k = 0; k < ND; k++) begin
            check("rst_level", k, 32'(lvl[k]), 32'd0);
            check("rst_done", k, 32'(dn[k]), 32'd0);
            check("rst_any", k, 32'(act[k]), 32'd0);
        end
        step(1, '0);
        step(1, '0);

        // Table: basic hold and retrigger on / off.
        for (int i = 0; i < 11; i++) begin
            step(1, tbl[i].t);
            check("tbl_lvl", 0, 32'(lvl[0]), 32'(tbl[i].l0));
            check("tbl_done", 0, 32'(dn[0]), 32'(tbl[i].d0));
            check("tbl_lvl", 1, 32'(lvl[1]), 32'(tbl[i].l1));
            check("tbl_done", 1, 32'(dn[1]), 32'(tbl[i].d1));
        end

        // Trigger on the final active cycle with retrigger off is ignored.
        step(1, 3'b001);
        for (int i = 0; i < 3; i++) step(1, '0);
        step(1, 3'b001);
        check("last_lvl", 0, 32'(lvl[0][0]), 32'd1);
        step(1, '0);
        check("last_ign_lvl", 1, 32'(lvl[1][0]), 32'd0);
        check("last_ign_done", 1, 32'(dn[1][0]), 32'd1);
        for (int i = 0; i < 8; i++) step(1, '0);

        // Held trigger: gaps with done when retrigger off, solid level when on.
        for (int i = 1; i <= 10; i++) begin
            step(1, 3'b111);
            check("held_r1", 4, 32'(lvl[4]), 32'h7);
            check("held_r0_gap", 3, 32'(dn[3]), (i % 4 == 0) ? 32'h7 : 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, '0);
            check("tail_r1", 4, 32'(lvl[4]), (i < 2) ? 32'h7 : 32'h0);
        end
        for (int i = 0; i < 6; i++) step(1, '0);

        // Reset mid-hold, then an immediate trigger after release.
        step(1, 3'b011);
        for (int i = 0; i < 3; i++) step(1, '0);
        step(0, '0);
        for (int k = 0; k < ND; k++) begin
            check("midrst_any", k, 32'(act[k]), 32'd0);
            check("midrst_done", k, 32'(dn[k]), 32'd0);
        end
        step(1, 3'b001);
        check("post_rst", 0, 32'(lvl[0]), 32'h1);
        for (int i = 0; i < 8; i++) step(1, '0);

        // Degenerate one-cycle hold on every channel at once.
        step(1, 3'b111);
        check("h1_lvl", 2, 32'(lvl[2]), 32'h7);
        step(1, '0);
        check("h1_lvl_off", 2, 32'(lvl[2]), 32'h0);
        check("h1_done", 2, 32'(dn[2]), 32'h7);
        step(1, '0);
        check("h1_done_off", 2, 32'(dn[2]), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [NC-1:0] t;
            for (int c = 0; c < NC; c++) t[c] = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 80) != 0), t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
